// File: rtl/gamma_lut_bank_scheduler.sv
// Purpose: buffers host gamma-LUT writes, drains them into the shadow bank, swaps banks at a frame edge after commit.
// Latency: push -> lut_we is 2 cycles minimum; active_bank/swap_pulse change the cycle after the qualifying vsync edge.
// Backpressure: wr_ready drops while the FIFO is full or a swap is armed. Optional ARMED timeout: GAMMA_SCHED_TIMEOUT_EN.

module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_vld,
  input  logic [WIDTH-1:0] push_dat,
  input  logic             pop_rdy,
  output logic [WIDTH-1:0] pop_dat,
  output logic             empty,
  output logic             full
);
  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW:0]      wr_ptr;
  logic [PW:0]      rd_ptr;

  // Pointer update; the extra MSB separates full from empty when the indices match.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push_vld) wr_ptr <= wr_ptr + 1'b1;
      if (pop_rdy)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage array; contents are don't-care until written, so no reset.
  always_ff @(posedge clk) begin
    if (push_vld) mem[wr_ptr[PW-1:0]] <= push_dat;
  end

  assign pop_dat = mem[rd_ptr[PW-1:0]];
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
endmodule

module gamma_lut_bank_scheduler #(
  parameter int ADDR_WIDTH     = 10,
  parameter int DATA_WIDTH     = 10,
  parameter int FIFO_DEPTH     = 8,
  parameter int VSYNC_POL      = 1,
  parameter int TIMEOUT_CYCLES = 4000000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  vsync_in,
  input  logic                  wr_valid,
  output logic                  wr_ready,
  input  logic [1:0]            wr_chan,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  commit,
  output logic [2:0]            lut_we,
  output logic [ADDR_WIDTH-1:0] lut_addr,
  output logic [DATA_WIDTH-1:0] lut_data,
  output logic                  lut_wr_bank,
  output logic                  active_bank,
  output logic                  swap_pulse,
  output logic                  busy,
  output logic                  timeout_flag
);
  localparam int   EW     = 2 + ADDR_WIDTH + DATA_WIDTH;
  localparam logic VS_INV = (VSYNC_POL == 0);

  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 || TIMEOUT_CYCLES < 1) begin : g_bad_params
    $error("gamma_lut_bank_scheduler: FIFO_DEPTH must be a power of 2 >= 2 and TIMEOUT_CYCLES >= 1");
  end

  typedef enum logic [1:0] {IDLE, DRAIN, ARMED, SWAP} state_t;

  typedef struct packed {
    logic [1:0]            chan;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] data;
  } wr_ent_t;

  state_t  state_q;
  state_t  state_d;
  wr_ent_t push_ent;
  wr_ent_t pop_ent;
  logic    fifo_empty;
  logic    fifo_full;
  logic    push;
  logic    pop;
  logic    vs_n;
  logic    vs_n_q;
  logic    frame_edge;
  logic    commit_ok;
  logic    commit_pending;
  logic    force_swap;

  assign wr_ready   = !fifo_full && (state_q != ARMED);
  assign push       = wr_valid && wr_ready;
  // Draining stops while armed so the shadow bank is frozen until the swap.
  assign pop        = !fifo_empty && (state_q != ARMED);
  assign push_ent   = '{chan: wr_chan, addr: wr_addr, data: wr_data};
  assign vs_n       = vsync_in ^ VS_INV;
  assign frame_edge = vs_n && !vs_n_q;
  // A commit is only honoured before the swap is armed; later ones would double-swap.
  assign commit_ok  = commit && ((state_q == IDLE) || (state_q == DRAIN));
  assign swap_pulse = (state_q == SWAP);
  assign busy       = (state_q != IDLE) || !fifo_empty || (|lut_we);

  sync_fifo #(.WIDTH(EW), .DEPTH(FIFO_DEPTH)) u_wr_fifo (
    .clk      (clk),
    .rst      (reset),
    .push_vld (push),
    .push_dat (push_ent),
    .pop_rdy  (pop),
    .pop_dat  (pop_ent),
    .empty    (fifo_empty),
    .full     (fifo_full)
  );

`ifdef GAMMA_SCHED_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] armed_cnt;
  logic          timeout_q;

  assign force_swap   = (state_q == ARMED) && !frame_edge && (armed_cnt == TW'(TIMEOUT_CYCLES - 1));
  assign timeout_flag = timeout_q;

  // Count cycles spent armed; restarts every time the FSM leaves ARMED.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                  armed_cnt <= '0;
    else if (state_q == ARMED)  armed_cnt <= armed_cnt + 1'b1;
    else                        armed_cnt <= '0;
  end

  // Sticky record of a forced swap, cleared by the next honoured commit.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)           timeout_q <= 1'b0;
    else if (force_swap) timeout_q <= 1'b1;
    else if (commit_ok)  timeout_q <= 1'b0;
  end
`else
  assign force_swap   = 1'b0;
  assign timeout_flag = 1'b0;
`endif

  // State register and vsync history for edge detection.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      vs_n_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      vs_n_q  <= vs_n;
    end
  end

  // Next-state logic. Writes arriving in the same cycle keep the FSM out of ARMED/IDLE
  // so every accepted write lands in the bank that the pending commit publishes.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (commit || push || !fifo_empty) state_d = DRAIN;
      end
      DRAIN: begin
        if (commit_pending && fifo_empty && (lut_we == 3'b000) && !push)
          state_d = ARMED;
        else if (fifo_empty && !commit_pending && !commit && !push)
          state_d = IDLE;
      end
      ARMED: begin
        if (frame_edge || force_swap) state_d = SWAP;
      end
      SWAP: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Pending commit: set by an honoured commit, consumed by the swap.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                 commit_pending <= 1'b0;
    else if (state_q == SWAP)  commit_pending <= 1'b0;
    else if (commit_ok)        commit_pending <= 1'b1;
  end

  // Bank flips on entry to SWAP so it changes together with swap_pulse.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                                   active_bank <= 1'b0;
    else if (state_q == ARMED && state_d == SWAP) active_bank <= ~active_bank;
  end

  // Registered LUT write port; lut_wr_bank is captured with each write so it stays aligned with lut_we.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lut_we      <= 3'b000;
      lut_addr    <= '0;
      lut_data    <= '0;
      lut_wr_bank <= 1'b0;
    end else if (pop) begin
      lut_we      <= (pop_ent.chan == 2'd3) ? 3'b111 : (3'b001 << pop_ent.chan);
      lut_addr    <= pop_ent.addr;
      lut_data    <= pop_ent.data;
      lut_wr_bank <= ~active_bank;
    end else begin
      lut_we      <= 3'b000;
    end
  end
endmodule

// File: tb/tb_gamma_lut_bank_scheduler.sv
// Bench for gamma_lut_bank_scheduler: constant vector table, hand-written corner sequences,
// and random traffic compared each cycle against a queue-based reference model.
`timescale 1ns/1ps
module tb_gamma_lut_bank_scheduler;
  localparam int AW    = 10;
  localparam int DW    = 10;
  localparam int DEPTH = 8;
  localparam int VPOL  = 1;
`ifdef GAMMA_SCHED_TIMEOUT_EN
  localparam int TO = 50;
`else
  localparam int TO = 4000000;
`endif

  logic          clk = 1'b0;
  logic          reset;
  logic          vsync_in, wr_valid, commit;
  logic [1:0]    wr_chan;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic          wr_ready, lut_wr_bank, active_bank, swap_pulse, busy, timeout_flag;
  logic [2:0]    lut_we;
  logic [AW-1:0] lut_addr;
  logic [DW-1:0] lut_data;

  always #5 clk = ~clk;

  gamma_lut_bank_scheduler #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH), .VSYNC_POL(VPOL), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .reset(reset), .vsync_in(vsync_in), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .wr_chan(wr_chan), .wr_addr(wr_addr), .wr_data(wr_data), .commit(commit),
    .lut_we(lut_we), .lut_addr(lut_addr), .lut_data(lut_data), .lut_wr_bank(lut_wr_bank),
    .active_bank(active_bank), .swap_pulse(swap_pulse), .busy(busy), .timeout_flag(timeout_flag)
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct packed {
    logic [1:0]    ch;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } ent_t;

  ent_t          mq[$];
  bit            m_drain, m_armed, m_swap, m_pend, m_active, m_bank, m_flag, m_vs_prev;
  logic [2:0]    m_we;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_data;
  int            m_cnt;

  function automatic logic [2:0] chan_we(input logic [1:0] ch);
    case (ch)
      2'd0:    return 3'b001;
      2'd1:    return 3'b010;
      2'd2:    return 3'b100;
      default: return 3'b111;
    endcase
  endfunction

  task automatic model_reset();
    mq.delete();
    m_drain = 0; m_armed = 0; m_swap = 0; m_pend = 0; m_active = 0; m_bank = 0;
    m_flag = 0; m_vs_prev = 0; m_we = 3'b000; m_addr = '0; m_data = '0; m_cnt = 0;
  endtask

  // Advance the model by one clock using the inputs currently applied.
  task automatic model_step();
    int         n0;
    bit         vsn, edge_s, push, pop, cm_ok, old_pend, was_armed, force_s;
    logic [2:0] old_we;
    ent_t       e;
    n0        = mq.size();
    vsn       = vsync_in ^ (VPOL == 0);
    edge_s    = vsn && !m_vs_prev;
    push      = wr_valid && (n0 < DEPTH) && !m_armed;
    pop       = (n0 != 0) && !m_armed;
    old_we    = m_we;
    old_pend  = m_pend;
    was_armed = m_armed;
    cm_ok     = commit && !m_armed && !m_swap;
`ifdef GAMMA_SCHED_TIMEOUT_EN
    force_s   = m_armed && !edge_s && (m_cnt == TO - 1);
`else
    force_s   = 0;
`endif
    if (pop) begin
      e = mq.pop_front();
      m_we = chan_we(e.ch); m_addr = e.a; m_data = e.d; m_bank = !m_active;
    end else begin
      m_we = 3'b000;
    end
    if (push) begin
      e.ch = wr_chan; e.a = wr_addr; e.d = wr_data;
      mq.push_back(e);
    end
    if (m_swap) begin
      m_swap = 0; m_pend = 0;
    end else if (m_armed) begin
      if (edge_s || force_s) begin
        if (!edge_s) m_flag = 1;
        m_armed = 0; m_swap = 1; m_active = !m_active;
      end
    end else if (m_drain) begin
      if (old_pend && n0 == 0 && old_we == 3'b000 && !push) begin
        m_drain = 0; m_armed = 1;
      end else if (n0 == 0 && !old_pend && !commit && !push) begin
        m_drain = 0;
      end
    end else if (commit || push || n0 != 0) begin
      m_drain = 1;
    end
    if (cm_ok) begin
      m_pend = 1; m_flag = 0;
    end
    m_cnt     = was_armed ? m_cnt + 1 : 0;
    m_vs_prev = vsn;
  endtask

  task automatic compare_model();
    logic [28:0] act, exp;
    bit          exp_rdy, exp_busy;
    exp_rdy  = (mq.size() < DEPTH) && !m_armed;
    exp_busy = m_drain || m_armed || m_swap || (mq.size() != 0) || (m_we != 3'b000);
    act = {wr_ready, busy, lut_we, lut_addr, lut_data, lut_wr_bank, active_bank, swap_pulse, timeout_flag};
    exp = {exp_rdy, exp_busy, m_we, m_addr, m_data, m_bank, m_active, m_swap, m_flag};
    check($sformatf("model_cycle%0d {rdy,busy,we,addr,data,bank,act,swap,tof}", cyc), 64'(act), 64'(exp));
  endtask

  // ---------------- sequence helpers ----------------
  bit   mon_en = 0;
  ent_t exp_q[$];
  int   n111, swap_cnt;

  task automatic tick();
    ent_t e;
    model_step();
    @(posedge clk);
    #1;
    cyc++;
    compare_model();
    if (lut_we == 3'b111) n111++;
    if (swap_pulse) swap_cnt++;
    if (mon_en && lut_we != 3'b000) begin
      if (exp_q.size() == 0) begin
        check("order_unexpected_write", 64'(lut_addr), 64'(0));
        if (lut_addr == '0) begin errors++; $display("FAIL order_unexpected_write: got a write expected none"); end
      end else begin
        e = exp_q.pop_front();
        check("order_we",   64'(lut_we),   64'(chan_we(e.ch)));
        check("order_addr", 64'(lut_addr), 64'(e.a));
        check("order_data", 64'(lut_data), 64'(e.d));
      end
    end
  endtask

  task automatic set_in(input logic v, input logic [1:0] ch, input logic [AW-1:0] a,
                        input logic [DW-1:0] d, input logic cm, input logic vs);
    wr_valid = v; wr_chan = ch; wr_addr = a; wr_data = d; commit = cm; vsync_in = vs;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    set_in(1'b0, 2'd0, '0, '0, 1'b0, 1'b0);
    model_reset();
    n111 = 0; swap_cnt = 0; mon_en = 0; exp_q.delete();
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    compare_model();
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic          v;
    logic [1:0]    ch;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    logic          cm, vs;
    logic [2:0]    we;
    logic [AW-1:0] ea;
    logic [DW-1:0] ed;
    logic          bank, act, sw, rdy, bsy;
  } vec_t;

  function automatic vec_t mk(input logic v, input logic [1:0] ch, input logic [AW-1:0] a,
                              input logic [DW-1:0] d, input logic cm, input logic vs,
                              input logic [2:0] we, input logic [AW-1:0] ea, input logic [DW-1:0] ed,
                              input logic bank, input logic act, input logic sw,
                              input logic rdy, input logic bsy);
    vec_t r;
    r.v = v; r.ch = ch; r.a = a; r.d = d; r.cm = cm; r.vs = vs;
    r.we = we; r.ea = ea; r.ed = ed; r.bank = bank; r.act = act; r.sw = sw; r.rdy = rdy; r.bsy = bsy;
    return r;
  endfunction

  vec_t tbl[10];

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic vs_state;
    reset = 1'b1;
    //             v     ch    addr    data      cm    vs    we      eaddr   edata     bank  act   swap  rdy   busy
    tbl[0] = mk(1'b1, 2'd1, 10'd5, 10'h3FF, 1'b0, 1'b0, 3'b000, 10'd0, 10'h000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    tbl[1] = mk(1'b0, 2'd0, 10'd0, 10'h000, 1'b0, 1'b0, 3'b010, 10'd5, 10'h3FF, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
    tbl[2] = mk(1'b0, 2'd0, 10'd0, 10'h000, 1'b0, 1'b0, 3'b000, 10'd0, 10'h000, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    tbl[3] = mk(1'b0, 2'd0, 10'd0, 10'h000, 1'b1, 1'b0, 3'b000, 10'd0, 10'h000, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
    tbl[4] = mk(1'b0, 2'd0, 10'd0, 10'h000, 1'b0, 1'b0, 3'b000, 10'd0, 10'h000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    tbl[5] = mk(1'b0, 2'd0, 10'd0, 10'h000, 1'b0, 1'b1, 3'b000, 10'd0, 10'h000, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
    tbl[6] = mk(1'b0, 2'd0, 10'd0, 10'h000, 1'b0, 1'b1, 3'b000, 10'd0, 10'h000, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    tbl[7] = mk(1'b1, 2'd3, 10'd7, 10'h155, 1'b0, 1'b1, 3'b000, 10'd0, 10'h000, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
    tbl[8] = mk(1'b0, 2'd0, 10'd0, 10'h000, 1'b0, 1'b0, 3'b111, 10'd7, 10'h155, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
    tbl[9] = mk(1'b0, 2'd0, 10'd0, 10'h000, 1'b0, 1'b0, 3'b000, 10'd0, 10'h000, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);

    // Reset state.
    do_reset();
    check("reset_active_bank", 64'(active_bank), 64'(0));
    check("reset_wr_ready",    64'(wr_ready),    64'(1));
    check("reset_busy",        64'(busy),        64'(0));
    check("reset_lut_we",      64'(lut_we),      64'(0));
    check("reset_swap_pulse",  64'(swap_pulse),  64'(0));

    // Table: single write latency, commit/arm/swap, broadcast write to the new shadow bank.
    for (int i = 0; i < 10; i++) begin
      set_in(tbl[i].v, tbl[i].ch, tbl[i].a, tbl[i].d, tbl[i].cm, tbl[i].vs);
      tick();
      check($sformatf("tbl%0d_we", i),     64'(lut_we),      64'(tbl[i].we));
      check($sformatf("tbl%0d_bank", i),   64'(lut_wr_bank), 64'(tbl[i].bank));
      check($sformatf("tbl%0d_active", i), 64'(active_bank), 64'(tbl[i].act));
      check($sformatf("tbl%0d_swap", i),   64'(swap_pulse),  64'(tbl[i].sw));
      check($sformatf("tbl%0d_ready", i),  64'(wr_ready),    64'(tbl[i].rdy));
      check($sformatf("tbl%0d_busy", i),   64'(busy),        64'(tbl[i].bsy));
      if (tbl[i].we != 3'b000) begin
        check($sformatf("tbl%0d_addr", i), 64'(lut_addr), 64'(tbl[i].ea));
        check($sformatf("tbl%0d_data", i), 64'(lut_data), 64'(tbl[i].ed));
      end
    end

    // A: writes refused while armed, then an 8-write burst keeps its order.
    do_reset();
    set_in(1'b0, 2'd0, '0, '0, 1'b1, 1'b0); tick();
    set_in(1'b0, 2'd0, '0, '0, 1'b0, 1'b0); tick();
    check("a_armed_ready", 64'(wr_ready), 64'(0));
    mon_en = 1;
    for (int i = 0; i < 3; i++) begin
      set_in(1'b1, 2'd0, 10'h3AA, 10'd1, 1'b0, 1'b0); tick();
      check("a_refused_ready", 64'(wr_ready), 64'(0));
    end
    set_in(1'b0, 2'd0, '0, '0, 1'b0, 1'b1); tick();
    check("a_swap", 64'(swap_pulse), 64'(1));
    for (int i = 0; i < 8; i++) begin
      ent_t e;
      e.ch = 2'(i % 4); e.a = AW'(16 + i); e.d = DW'(i * 37 + 3);
      exp_q.push_back(e);
      set_in(1'b1, e.ch, e.a, e.d, 1'b0, 1'b1); tick();
    end
    set_in(1'b0, 2'd0, '0, '0, 1'b0, 1'b1);
    repeat (6) tick();
    check("a_all8_written", 64'(exp_q.size()), 64'(0));
    mon_en = 0;

`ifndef GAMMA_SCHED_TIMEOUT_EN
    // B: three broadcast writes + commit, vsync rises 100 cycles later.
    do_reset();
    for (int i = 0; i < 3; i++) begin
      set_in(1'b1, 2'd3, AW'(i), DW'(256 + i), 1'b0, 1'b0); tick();
    end
    set_in(1'b0, 2'd0, '0, '0, 1'b1, 1'b0); tick();
    set_in(1'b0, 2'd0, '0, '0, 1'b0, 1'b0);
    repeat (100) tick();
    check("b_three_111_writes", 64'(n111), 64'(3));
    check("b_armed_ready",      64'(wr_ready), 64'(0));
    check("b_no_early_swap",    64'(active_bank), 64'(0));
    set_in(1'b0, 2'd0, '0, '0, 1'b0, 1'b1); tick();
    check("b_swap_pulse",  64'(swap_pulse),  64'(1));
    check("b_active_bank", 64'(active_bank), 64'(1));
    tick();
    check("b_swap_one_cycle", 64'(swap_pulse), 64'(0));

    // C: commit coincident with an edge is not swapped on that edge; a second commit while armed is ignored.
    do_reset();
    set_in(1'b0, 2'd0, '0, '0, 1'b1, 1'b1); tick();
    set_in(1'b0, 2'd0, '0, '0, 1'b0, 1'b1);
    repeat (5) tick();
    check("c_no_swap_same_edge", 64'(active_bank), 64'(0));
    set_in(1'b0, 2'd0, '0, '0, 1'b0, 1'b0); repeat (3) tick();
    set_in(1'b0, 2'd0, '0, '0, 1'b1, 1'b0); tick();
    set_in(1'b0, 2'd0, '0, '0, 1'b0, 1'b1); tick();
    check("c_swap_next_edge", 64'(swap_pulse), 64'(1));
    repeat (3) tick();
    set_in(1'b0, 2'd0, '0, '0, 1'b0, 1'b0); repeat (2) tick();
    set_in(1'b0, 2'd0, '0, '0, 1'b0, 1'b1); repeat (3) tick();
    check("c_single_swap", 64'(swap_cnt), 64'(1));
    check("c_active_bank", 64'(active_bank), 64'(1));

    // D: reset while armed discards queued state and returns to bank 0.
    set_in(1'b1, 2'd2, 10'd9, 10'd9, 1'b0, 1'b0); tick();
    set_in(1'b0, 2'd0, '0, '0, 1'b1, 1'b0); repeat (4) tick();
    check("d_armed_before_reset", 64'(wr_ready), 64'(0));
    do_reset();
    check("d_active_after_reset", 64'(active_bank), 64'(0));
    check("d_busy_after_reset",   64'(busy), 64'(0));
    repeat (4) tick();
    check("d_no_stale_writes", 64'(n111) + 64'(swap_cnt), 64'(0));
`else
    // T: with no vsync the armed swap is forced on the TO-th armed cycle.
    do_reset();
    set_in(1'b0, 2'd0, '0, '0, 1'b1, 1'b0); tick();
    set_in(1'b0, 2'd0, '0, '0, 1'b0, 1'b0); tick();
    begin
      int first = -1;
      for (int k = 1; k <= TO + 5; k++) begin
        tick();
        if (swap_pulse && first < 0) first = k;
      end
      check("t_forced_swap_cycle", 64'(first), 64'(TO));
    end
    check("t_flag_set",   64'(timeout_flag), 64'(1));
    check("t_single",     64'(swap_cnt), 64'(1));
    set_in(1'b0, 2'd0, '0, '0, 1'b1, 1'b0); tick();
    check("t_flag_clear", 64'(timeout_flag), 64'(0));
`endif

    // Random traffic against the model.
    do_reset();
    vs_state = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 24) == 0) vs_state = ~vs_state;
      set_in(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), AW'($urandom),
             DW'($urandom), ($urandom_range(0, 31) == 0), vs_state);
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
